// File: rtl/wrr4_pkg.sv
// Shared definitions for the 4-requester weighted round-robin burst scheduler.
// Holds the requester count, index and weight-field widths, FSM states and small bit helpers.
package wrr4_pkg;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int WEIGHT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                id = id | ID_W'(i);
            end
        end
        return id;
    endfunction

    // Isolates the least significant set bit (two's-complement trick).
    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

endpackage

// File: rtl/wrr4_burst_sched_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning upward and wrapping from the top requester back to requester 0.
module wrr4_pick
    import wrr4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/wrr4_burst_sched.sv
// Weighted round-robin scheduler granting one of four requesters a burst of weight+1 transactions.
// Optional starvation override is compiled in with the macro WRR4_STARVE_EN.
module wrr4_burst_sched
    import wrr4_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [7:0]          weight,
    input  logic                res_ready,
    input  logic                done,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic [NUM_REQ-1:0]  starve_flag
);

    state_t                state;
    logic [ID_W-1:0]       ptr;
    logic [WEIGHT_W-1:0]   qcnt;

    logic [ID_W-1:0]       pick_ptr;
    logic [NUM_REQ-1:0]    rr_pick;
    logic                  rr_valid;
    logic [NUM_REQ-1:0]    override_pick;
    logic                  override;
    logic [NUM_REQ-1:0]    next_winner;
    logic                  next_valid;
    logic [ID_W-1:0]       next_id;
    logic [WEIGHT_W-1:0]   next_weight;
    logic                  retain;

    // On done the search starts just past the finishing grantee, so the
    // next winner is ready in the same cycle and no idle bubble appears.
    assign pick_ptr = (state == BUSY) ? grant_id + ID_W'(1) : ptr;

    wrr4_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .pick  (rr_pick),
        .valid (rr_valid)
    );

    assign next_winner = override ? override_pick : rr_pick;
    assign next_valid  = override | rr_valid;
    assign next_id     = onehot_to_id(next_winner);
    assign next_weight = weight[int'(next_id)*WEIGHT_W +: WEIGHT_W];
    assign retain      = req[grant_id] && (qcnt != '0) && !override;

`ifdef WRR4_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]   starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starved_req;
    logic               honoured_done;
    logic               fresh_select;

    assign honoured_done = (state == BUSY) && done;
    assign fresh_select  = next_valid && ((state == IDLE) || (honoured_done && !retain));

    // A waiting requester ages once per completed transaction of someone else;
    // being selected wipes its age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fresh_select && next_winner[i]) begin
                    starve_cnt[i] <= '0;
                end else if (honoured_done && req[i] && (grant_id != ID_W'(i)) &&
                             (starve_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        starve_flag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_flag[i] = (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    assign starved_req   = starve_flag & req;
    assign override      = |starved_req;
    assign override_pick = lowest_set(starved_req);
`else
    logic unused_starve_limit;

    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign starve_flag         = '0;
    assign override            = 1'b0;
    assign override_pick       = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            qcnt        <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_valid) begin
                        grant       <= next_winner;
                        grant_valid <= 1'b1;
                        grant_id    <= next_id;
                        qcnt        <= next_weight;
                        state       <= OFFER;
                    end
                end

                // Acceptance takes precedence over a request dropping in the same cycle.
                OFFER: begin
                    if (res_ready) begin
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else if (!req[grant_id]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        state       <= IDLE;
                    end
                end

                BUSY: begin
                    if (done) begin
                        busy <= 1'b0;
                        if (retain) begin
                            qcnt  <= qcnt - WEIGHT_W'(1);
                            state <= OFFER;
                        end else begin
                            ptr <= grant_id + ID_W'(1);
                            if (next_valid) begin
                                grant       <= next_winner;
                                grant_valid <= 1'b1;
                                grant_id    <= next_id;
                                qcnt        <= next_weight;
                                state       <= OFFER;
                            end else begin
                                grant       <= '0;
                                grant_valid <= 1'b0;
                                grant_id    <= '0;
                                state       <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_id    <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr4_burst_sched.sv
// Directed self-checking bench for wrr4_burst_sched; covers the starvation
// override when built with WRR4_STARVE_EN and pure weighted round-robin otherwise.
module tb_wrr4_burst_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] weight;
    logic       res_ready;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] starve_flag;

    int checks   = 0;
    int failures = 0;

    wrr4_burst_sched #(.STARVE_LIMIT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .weight      (weight),
        .res_ready   (res_ready),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .starve_flag (starve_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        done  = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b0110; weight = 8'h00; res_ready = 1'b1; done = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: grant=%b gv=%b busy=%b id=%0d, expected 0000 0 0 0",
                     grant, grant_valid, busy, grant_id);
        end
        checks++;
        if (starve_flag !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_starve: got %b expected 0000", starve_flag);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_valid !== 1'b1 || grant_id !== 2'd1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_grant: grant=%b gv=%b id=%0d busy=%b, expected 0010 1 1 0",
                     grant, grant_valid, grant_id, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL accept_busy: busy=%b grant=%b, expected 1 0010", busy, grant);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111; weight = 8'h00; res_ready = 1'b1;
        do_reset();
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL rotate_start: got %b expected 0001", grant);
        end
        tick();
        for (int n = 0; n < 4; n++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== exp_seq[n] || grant_valid !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rotate_%0d: grant=%b gv=%b busy=%b, expected %b 1 0",
                         n, grant, grant_valid, busy, exp_seq[n]);
            end
            tick();
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rotate_busy_%0d: got %b expected 1", n, busy);
            end
        end
    endtask

    task automatic test_quantum();
        logic [3:0] exp_seq [3] = '{4'b0001, 4'b0001, 4'b0010};
        req = 4'b1111; weight = 8'h02; res_ready = 1'b1;
        do_reset();
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL quantum_start: got %b expected 0001", grant);
        end
        tick();
        for (int n = 0; n < 3; n++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== exp_seq[n] || grant_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL quantum_%0d: grant=%b gv=%b, expected %b 1",
                         n, grant, grant_valid, exp_seq[n]);
            end
            tick();
        end
    endtask

    task automatic test_withdraw();
        req = 4'b0010; weight = 8'h00; res_ready = 1'b1;
        do_reset();
        tick();
        tick();
        req = 4'b0110; res_ready = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL withdraw_offer: grant=%b gv=%b, expected 0100 1", grant, grant_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b0 || grant_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_in_offer: grant=%b busy=%b gv=%b, expected 0100 0 1",
                     grant, busy, grant_valid);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL withdraw_drop: gv=%b grant=%b, expected 0 0000", grant_valid, grant);
        end
        tick();
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            failures++;
            $display("[TB] FAIL withdraw_rerequest: grant=%b id=%0d, expected 0100 2", grant, grant_id);
        end
    endtask

    task automatic test_starve();
        req = 4'b1001; weight = 8'h03; res_ready = 1'b1;
        do_reset();
        tick();
        tick();
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 4'b0001 || starve_flag !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL starve_done1: grant=%b flag=%b, expected 0001 0000", grant, starve_flag);
        end
        tick();
        done = 1'b1; tick(); done = 1'b0;
`ifdef WRR4_STARVE_EN
        checks++;
        if (grant !== 4'b0001 || starve_flag !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL starve_done2: grant=%b flag=%b, expected 0001 1000", grant, starve_flag);
        end
        tick();
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 4'b1000 || starve_flag !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL starve_override: grant=%b flag=%b, expected 1000 0000", grant, starve_flag);
        end
`else
        checks++;
        if (grant !== 4'b0001 || starve_flag !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL nostarve_done2: grant=%b flag=%b, expected 0001 0000", grant, starve_flag);
        end
        tick();
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 4'b0001 || starve_flag !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL nostarve_done3: grant=%b flag=%b, expected 0001 0000", grant, starve_flag);
        end
`endif
    endtask

    task automatic test_reset_busy();
        req = 4'b0100; weight = 8'h00; res_ready = 1'b1;
        do_reset();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL pre_reset_busy: busy=%b grant=%b, expected 1 0100", busy, grant);
        end
        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: grant=%b busy=%b gv=%b id=%0d, expected 0000 0 0 0",
                     grant, busy, grant_valid, grant_id);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_grant: grant=%b gv=%b, expected 0001 1", grant, grant_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; weight = 8'h00; res_ready = 1'b0; done = 1'b0;
        test_reset();
        test_rotate();
        test_quantum();
        test_withdraw();
        test_starve();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
